// File: rtl/volume_pkg.sv
// Shared definitions for the volume meter and playback gain FSMs:
// state encoding, gain level type and the thermometer volume codes.
package volume_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCALE = 2'd1,
      STEP  = 2'd2
   } state_e;

   typedef logic [2:0] level_t;

   localparam logic [7:0] VOL_L0 = 8'h00;
   localparam logic [7:0] VOL_L1 = 8'h80;
   localparam logic [7:0] VOL_L2 = 8'hE0;
   localparam logic [7:0] VOL_L3 = 8'hF0;
   localparam logic [7:0] VOL_L4 = 8'hF8;
   localparam logic [7:0] VOL_L5 = 8'hFC;
   localparam logic [7:0] VOL_L6 = 8'hFE;
   localparam logic [7:0] VOL_L7 = 8'hFF;

endpackage

// File: rtl/volume_code_decoder.sv
// Maps a thermometer volume code to a gain level. The lowest set bit wins,
// so malformed codes still land on a deterministic level.
module volume_code_decoder
   import volume_pkg::*;
(
   input  logic [7:0] volume_code,
   output level_t     target
);

   always_comb begin
      target = 3'd0;
      if (volume_code[0])
         target = 3'd7;
      else if (volume_code[1])
         target = 3'd6;
      else if (volume_code[2])
         target = 3'd5;
      else if (volume_code[3])
         target = 3'd4;
      else if (volume_code[4])
         target = 3'd3;
      else if (volume_code[5])
         target = 3'd2;
      else if (volume_code[7] | volume_code[6])
         target = 3'd1;
   end

endmodule

// File: rtl/volume_scale_fsm.sv
// Applies the current gain level to one signed sample per start edge and
// slews the level one step toward the requested volume every RAMP_SAMPLES samples.
module volume_scale_fsm
   import volume_pkg::*;
#(
   parameter int RAMP_SAMPLES = 16,
   parameter int RESET_LEVEL  = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] sample,
   input  logic [7:0] volume_code,
   output logic [7:0] out_sample,
   output logic       finish,
   output logic [2:0] level
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_SCALE = SCALE;
   localparam logic [1:0] S_STEP  = STEP;

   localparam int              CW         = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;
   localparam logic [CW-1:0]   RAMP_LAST  = CW'(RAMP_SAMPLES - 1);
   localparam level_t          LEVEL_INIT = level_t'(RESET_LEVEL);

   logic [1:0]        state;
   logic              start_q;
   logic [CW-1:0]     ramp_count;
   level_t            target;
   logic              start_edge;
   logic              ramp_wrap;
   logic signed [7:0] shifted;
   logic [7:0]        scaled;

   volume_code_decoder u_decoder (
      .volume_code (volume_code),
      .target      (target)
   );

   assign start_edge = start & ~start_q;
   assign ramp_wrap  = (ramp_count == RAMP_LAST);
   assign finish     = (state == S_IDLE);

   // Level 7 is unity gain; each lower level halves the sample, rounding toward -inf.
   assign shifted = $signed(sample) >>> (3'd7 - level);
   assign scaled  = (level == 3'd0) ? 8'h00 : shifted;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         start_q    <= 1'b0;
         out_sample <= 8'h00;
         level      <= LEVEL_INIT;
         ramp_count <= '0;
      end else begin
         start_q <= start;
         case (state)
            S_IDLE: begin
               if (start_edge)
                  state <= S_SCALE;
            end
            S_SCALE: begin
               out_sample <= scaled;
               ramp_count <= ramp_wrap ? '0 : ramp_count + CW'(1);
               state      <= ramp_wrap ? S_STEP : S_IDLE;
            end
            // The target is only looked at here, so volume_code can move freely in between.
            S_STEP: begin
               if (level < target)
                  level <= level + 3'd1;
               else if (level > target)
                  level <= level - 3'd1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_volume_scale_fsm.sv
// Directed bench for volume_scale_fsm: a reference model predicts each scaled
// sample and gain level; expected samples queue at drive time and are popped on finish.
module tb_volume_scale_fsm;
   import volume_pkg::*;

   localparam int RAMP = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] sample;
   logic [7:0] volume_code;
   logic [7:0] out_sample;
   logic       finish;
   logic [2:0] level;

   int         n_asserts = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   int         m_level;
   int         m_cnt;
   logic [7:0] m_last;

   always #5 clk = ~clk;

   volume_scale_fsm #(
      .RAMP_SAMPLES (RAMP),
      .RESET_LEVEL  (0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .sample      (sample),
      .volume_code (volume_code),
      .out_sample  (out_sample),
      .finish      (finish),
      .level       (level)
   );

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_decode(input logic [7:0] code);
      for (int i = 0; i < 6; i++)
         if (code[i]) return 7 - i;
      if (code[7] || code[6]) return 1;
      return 0;
   endfunction

   // Floor division by a power of two, written independently of any shifter.
   function automatic logic [7:0] model_scale(input logic [7:0] s, input int lvl);
      int v, d, q;
      if (lvl == 0) return 8'h00;
      v = $signed(s);
      d = 1 << (7 - lvl);
      if (v >= 0) q = v / d;
      else        q = -((-v + d - 1) / d);
      return 8'(q);
   endfunction

   // mode 0: normal pulse, 1: extra edge during STEP, 2: start left high
   task automatic apply_stimulus(input logic [7:0] s, input int mode);
      logic [7:0] exp;
      bit         step;
      int         n;
      int         tgt;
      exp = model_scale(s, m_level);
      exp_q.push_back(exp);
      step  = (m_cnt == RAMP - 1);
      m_cnt = step ? 0 : m_cnt + 1;
      @(negedge clk);
      sample = s;
      start  = 1'b1;
      @(posedge clk); #1;
      n = 1;
      check_output("finish_low_after_edge", finish, 0);
      if (mode == 1) begin
         @(negedge clk); start = 1'b0;
         @(posedge clk); #1; n++;
         @(negedge clk); start = 1'b1;
      end else if (mode == 0) begin
         @(negedge clk); start = 1'b0;
      end
      while (finish !== 1'b1 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check_output("latency", n, step ? 3 : 2);
      if (step) begin
         tgt = model_decode(volume_code);
         if (m_level < tgt) m_level++;
         else if (m_level > tgt) m_level--;
      end
      m_last = exp_q.pop_front();
      check_output("out_sample", out_sample, m_last);
      check_output("level", level, m_level);
   endtask

   task automatic hold_check(input logic [7:0] exp_out);
      int lows = 0;
      sample = ~sample;
      repeat (50) begin
         @(posedge clk); #1;
         if (finish !== 1'b1) lows++;
      end
      check_output("hold_no_restart", lows, 0);
      check_output("hold_out_stable", out_sample, exp_out);
      check_output("hold_level", level, m_level);
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int guard;
      reset       = 1'b1;
      start       = 1'b0;
      sample      = 8'h00;
      volume_code = VOL_L0;
      m_level     = 0;
      m_cnt       = 0;

      // Reset values, then one muted sample
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_finish", finish, 1);
      check_output("reset_out", out_sample, 8'h00);
      check_output("reset_level", level, 0);
      @(negedge clk);
      reset = 1'b0;
      apply_stimulus(8'h40, 0);
      check_output("t1_muted", out_sample, 8'h00);

      // Full-scale ramp up
      $display("[TB] ramp up to full scale");
      volume_code = VOL_L7;
      repeat (112) apply_stimulus(8'h40, 0);
      check_output("t2_level7", level, 7);
      apply_stimulus(8'h40, 0);
      check_output("t2_passthrough", out_sample, 8'h40);

      // Ramp down to level 4 and check rounding
      $display("[TB] level 4 scaling");
      volume_code = VOL_L4;
      guard = 0;
      while (m_level != 4 && guard < 100) begin
         apply_stimulus(8'h7F, 0);
         guard++;
      end
      check_output("t3_level4", level, 4);
      apply_stimulus(8'h80, 0);
      check_output("t3_80", out_sample, 8'hF0);
      apply_stimulus(8'h7F, 0);
      check_output("t3_7F", out_sample, 8'h0F);
      apply_stimulus(8'h01, 0);
      check_output("t3_01", out_sample, 8'h00);
      apply_stimulus(8'hFF, 0);
      check_output("t3_FF", out_sample, 8'hFF);
      volume_code = VOL_L7;
      guard = 0;
      while (m_level != 7 && guard < 100) begin
         apply_stimulus(8'(guard * 37), 0);
         guard++;
      end
      apply_stimulus(8'h80, 0);
      check_output("t3_80_full", out_sample, 8'h80);

      // Ramp down to mute
      $display("[TB] ramp down to mute");
      volume_code = VOL_L0;
      repeat (112) apply_stimulus(8'h7F, 0);
      check_output("t4_level0", level, 0);
      apply_stimulus(8'h7F, 0);
      check_output("t4_muted", out_sample, 8'h00);

      // Lost edge during STEP, then start held high
      $display("[TB] start glitches and hold");
      volume_code = VOL_L7;
      guard = 0;
      while (m_cnt != RAMP - 1 && guard < 40) begin
         apply_stimulus(8'($urandom), 0);
         guard++;
      end
      apply_stimulus(8'h55, 1);
      hold_check(m_last);
      apply_stimulus(8'hA0, 2);
      hold_check(m_last);

      // Reset while scaling, then invalid code
      $display("[TB] reset during SCALE");
      @(negedge clk);
      sample = 8'h40;
      start  = 1'b1;
      @(posedge clk); #1;
      check_output("t6_in_scale", finish, 0);
      reset = 1'b1;
      #1;
      check_output("t6_finish", finish, 1);
      check_output("t6_level", level, 0);
      check_output("t6_out", out_sample, 8'h00);
      @(negedge clk);
      reset   = 1'b0;
      start   = 1'b0;
      m_level = 0;
      m_cnt   = 0;
      exp_q.delete();
      volume_code = 8'h40;
      repeat (40) apply_stimulus(8'($urandom), 0);
      check_output("t6_invalid_holds_1", level, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
